// File: rtl/simplez_core.sv
// -----------------------------------------------------------------------------
// simplez_core
//   Parametrised Simplez CPU: sequencer plus datapath that runs all eight
//   Simplez instructions (ST, LD, ADD, BR, BZ, CLR, DEC, HALT) against an
//   external synchronous memory. All state changes on the falling clock edge
//   so the core lines up with the memory block.
//
//   Instruction word (DW = AW+3 bits): CO = [DW-1:DW-3], CD = [AW-1:0].
//   Sequencer states: F0 (fetch address) -> F1 (latch RI) -> D (execute)
//   -> O (operand return for LD/ADD) or back to F0; HALT parks in H.
//
// Ports
//   clk         system clock, active edge is negedge
//   rst         synchronous active-high reset (same edge)
//   resume      in H, a high level at the edge restarts execution at PC
//   mem_addr    memory address (combinational from state)
//   mem_re      memory read enable; data returns the following cycle
//   mem_rdata   registered memory read data
//   mem_we      memory write enable; write commits on the edge
//   mem_wdata   write data, always AC
//   acc         accumulator AC
//   pc          program counter
//   halted      high while in H
//   instr_done  one-cycle pulse in the final cycle of each instruction
//
// Handshake with memory: a request (mem_re or mem_we high) is taken on the
// active edge it is presented on; there is no stall, read data is valid for
// exactly the next cycle.
// -----------------------------------------------------------------------------
module simplez_core #(
    parameter int AW       = 9,
    parameter int RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          resume,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    input  logic [AW+2:0] mem_rdata,
    output logic          mem_we,
    output logic [AW+2:0] mem_wdata,
    output logic [AW+2:0] acc,
    output logic [AW-1:0] pc,
    output logic          halted,
    output logic          instr_done
);

    localparam int DW = AW + 3;
    localparam logic [AW-1:0] RESET_PC_V = AW'(RESET_PC);

    localparam logic [2:0] OP_ST   = 3'd0;
    localparam logic [2:0] OP_LD   = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_BR   = 3'd3;
    localparam logic [2:0] OP_BZ   = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;
    localparam logic [2:0] OP_DEC  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    typedef enum logic [2:0] {
        S_F0 = 3'd0,
        S_F1 = 3'd1,
        S_D  = 3'd2,
        S_O  = 3'd3,
        S_H  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ac_q, ac_d;
    logic [DW-1:0] ri_q, ri_d;

    logic [2:0]    co;
    logic [AW-1:0] cd;
    logic          re_raw;
    logic          we_raw;

    assign co = ri_q[DW-1:DW-3];
    assign cd = ri_q[AW-1:0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ac_d       = ac_q;
        ri_d       = ri_q;
        mem_addr   = pc_q;
        re_raw     = 1'b0;
        we_raw     = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            S_F0: begin
                re_raw  = 1'b1;
                pc_d    = pc_q + AW'(1);
                state_d = S_F1;
            end
            S_F1: begin
                ri_d    = mem_rdata;
                state_d = S_D;
            end
            S_D: begin
                state_d    = S_F0;
                instr_done = 1'b1;
                case (co)
                    OP_ST: begin
                        mem_addr = cd;
                        we_raw   = 1'b1;
                    end
                    OP_LD, OP_ADD: begin
                        // Operand read issued here; the instruction retires in O.
                        mem_addr   = cd;
                        re_raw     = 1'b1;
                        state_d    = S_O;
                        instr_done = 1'b0;
                    end
                    OP_BR:   pc_d = cd;
                    OP_BZ:   if (ac_q == '0) pc_d = cd;
                    OP_CLR:  ac_d = '0;
                    OP_DEC:  ac_d = ac_q - DW'(1);
                    OP_HALT: state_d = S_H;
                    default: state_d = S_F0;
                endcase
            end
            S_O: begin
                instr_done = 1'b1;
                state_d    = S_F0;
                if (co == OP_LD) ac_d = mem_rdata;
                else             ac_d = ac_q + mem_rdata;
            end
            S_H: begin
                if (resume) state_d = S_F0;
            end
            default: state_d = S_F0;
        endcase
    end

    // Reset masks the strobes combinationally so a reset landing in D of an
    // ST cannot commit a write on that same edge.
    assign mem_re    = re_raw & ~rst;
    assign mem_we    = we_raw & ~rst;
    assign mem_wdata = ac_q;
    assign acc       = ac_q;
    assign pc        = pc_q;
    assign halted    = (state_q == S_H);

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q <= S_F0;
            pc_q    <= RESET_PC_V;
            ac_q    <= '0;
            ri_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ac_q    <= ac_d;
            ri_q    <= ri_d;
        end
    end

endmodule

// File: doc/simplez_core.md
Name: simplez_core

Overview:
- Complete parametrised Simplez CPU sequencer and datapath. Executes all eight Simplez instructions: ST, LD, ADD, BR, BZ, CLR, DEC and HALT.
- Generalised address width; data width follows from it (3-bit opcode plus AW-bit address field).
- Talks to an external synchronous memory (the `memory` block or a wider equivalent) through a read/write port.
- New versus the current core: all instructions executed, resumable HALT, per-instruction retire pulse, configurable reset PC.

Parameters:
- AW, 9, address width and width of the CD field; localparam DW = AW+3 is the data/instruction width.
- RESET_PC, 0, value loaded into PC on reset (must fit in AW bits).

Ports:
- clk  in  1  system clock; all state updates on the falling edge (negedge clk), matching the memory block.
- rst  in  1  synchronous, active-high reset, sampled on the same edge.
- resume  in  1  in HALT state, a high level sampled at the clock edge restarts execution.
- mem_addr  out  AW  memory address (combinational from state).
- mem_re  out  1  memory read enable; read data is valid in the cycle after the read edge.
- mem_rdata  in  DW  registered memory read data.
- mem_we  out  1  memory write enable; write commits on the clock edge.
- mem_wdata  out  DW  write data, always equal to AC.
- acc  out  DW  accumulator AC.
- pc  out  AW  program counter.
- halted  out  1  high while in state H.
- instr_done  out  1  one-cycle pulse in the last cycle of every instruction, HALT included.

Behaviour:
- Decode fields: CO = RI[DW-1:DW-3], CD = RI[AW-1:0].
- Opcodes (octal): 0 ST, 1 LD, 2 ADD, 3 BR, 4 BZ, 5 CLR, 6 DEC, 7 HALT.
- States: F0, F1, D, O, H.
- F0: mem_addr=PC, mem_re=1. At the edge, PC<=PC+1 (wraps mod 2^AW), then go to F1.
- F1: mem_re=0. At the edge, RI<=mem_rdata, then go to D.
- D, executes RI:
  - ST: mem_addr=CD, mem_we=1, then go to F0.
  - LD/ADD: mem_addr=CD, mem_re=1, then go to O.
  - BR: PC<=CD, then go to F0.
  - BZ: if AC==0 then PC<=CD, else PC unchanged; then go to F0.
  - CLR: AC<=0, then go to F0.
  - DEC: AC<=AC-1 mod 2^DW (0 wraps to all-ones), then go to F0.
  - HALT: go to H.
- O: LD gives AC<=mem_rdata; ADD gives AC<=AC+mem_rdata mod 2^DW, with no carry/flag. Then go to F0.
- H: halted=1, mem_re=mem_we=0, PC already points past the HALT.
  - resume=1 at the edge: go to F0, continue at PC.
  - Otherwise stay in H.
  - resume is ignored in all other states.
- instr_done=1:
  - in D for ST, BR, BZ, CLR and DEC;
  - in O for LD and ADD;
  - in D for HALT (the cycle before H).
- Cycle counts (edges per instruction):
  - ST, BR, BZ, CLR, DEC: 3.
  - LD, ADD: 4.
  - HALT: 3 to reach H.
- mem_addr default when not otherwise specified: PC.
- mem_wdata = AC always.
- Reset:
  - rst=1 at the edge: state<=F0, PC<=RESET_PC, AC<=0, RI<=0.
  - Reset overrides every transition, including mid-LD, mid-ST and H.
  - While rst is high, mem_we and mem_re are forced to 0 combinationally. No spurious write can occur in the reset cycle.
- After reset deassertion, the first fetch address is RESET_PC, issued in the first cycle.
- PC wrap: fetch at address 2^AW-1 continues at 0.
- A branch to the current address is legal (tight loop).

Test Plan:
- Add-and-store (AW=9):
  - Preload mem[0]=o1010 (LD 10), mem[1]=o2011 (ADD 11), mem[2]=o0012 (ST 12), mem[3]=o7000 (HALT); mem[o10]=5, mem[o11]=7.
  - Release rst. Required: mem[o12]=12, acc=12, pc=4, halted=1 exactly 14 edges after reset release, 4 instr_done pulses.
- Branch on zero:
  - Program CLR; BZ 6; DEC; HALT at 6.
  - Required: BZ taken, acc=0, halted with pc=7, DEC never executed (acc never o7777).
  - Repeat with DEC before BZ: BZ falls through, acc=o7777.
- DEC wrap and ADD overflow:
  - CLR; DEC gives acc=o7777.
  - Then ADD of a word holding 2 gives acc=1, with no other side effect.
- Resume:
  - HALT at 0, CLR at 1, HALT at 2.
  - halted stays high for 20 cycles with resume=0.
  - Pulse resume one cycle: halted drops, CLR retires, halted rises again with pc=3.
- Reset mid-operation:
  - Assert rst during state D of an ST.
  - Required: mem_we=0 in that cycle, target word unchanged, next fetch from RESET_PC.
  - Rerun with RESET_PC=5: first mem_addr=5.
- Narrow instance AW=5 (DW=8):
  - Store o7000-equivalent HALT at 31 and a BR 31 at 0.
  - Required: jump to 31, halted with pc wrapped to 0.
